// File: rtl/tms_sequencer.sv
// tms_sequencer: TMS1000-style ROM address sequencer (pc LFSR, page/chapter buffers, return stack).
// Latency: an accepted command updates state on the next rising edge; rom_addr reflects it one cycle later.
// Backpressure: cmd_ready is low during reset and the first cycle after; afterwards every command is taken.
// Ports: clk/reset (sync, active-high); cmd_valid/cmd_ready handshake; cmd, target, operand, status inputs;
//        rom_addr = {chapter, page, pc}; stack_level, in_sub, stack_overflow (sticky) status outputs.
// Config macro TMS_LEGACY_RETN_EN: RETN takes its page from the page buffer instead of the stack entry.
module tms_sequencer #(
  parameter int CHAPTER_BITS = 1,
  parameter int STACK_DEPTH  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd,
  input  logic [5:0]               target,
  input  logic [3:0]               operand,
  input  logic                     status,
  output logic [CHAPTER_BITS+9:0]  rom_addr,
  output logic [3:0]               stack_level,
  output logic                     in_sub,
  output logic                     stack_overflow
);

  localparam int EW = CHAPTER_BITS + 10;
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    C_SEQ  = 3'd0,
    C_BR   = 3'd1,
    C_CALL = 3'd2,
    C_RETN = 3'd3,
    C_LDP  = 3'd4,
    C_COMC = 3'd5,
    C_LDC  = 3'd6,
    C_SEQ7 = 3'd7
  } cmd_e;

  logic [5:0]              r_pc;
  logic [3:0]              r_page;
  logic [3:0]              r_pb;
  logic [CHAPTER_BITS-1:0] r_ch;
  logic [CHAPTER_BITS-1:0] r_cb;
  logic [3:0]              r_level;
  logic                    r_ovf;
  logic                    r_rdy;
  logic [EW-1:0]           r_stack [STACK_DEPTH];

  logic [5:0]              w_pc_seq;
  logic                    w_accept;
  logic                    w_full;
  logic [3:0]              w_pop_lvl;
  logic [IW-1:0]           w_push_idx;
  logic [IW-1:0]           w_pop_idx;
  logic [EW-1:0]           w_pop_dat;
  logic [5:0]              w_pc_d;
  logic [3:0]              w_page_d;
  logic [3:0]              w_pb_d;
  logic [CHAPTER_BITS-1:0] w_ch_d;
  logic [CHAPTER_BITS-1:0] w_cb_d;
  logic [3:0]              w_lvl_d;
  logic                    w_ovf_d;
  logic                    w_push;

  // 6-bit feedback shift register; 0x1F and 0x3F are patched so the sequence covers all 64 states.
  always_comb begin
    if (r_pc == 6'h1F)      w_pc_seq = 6'h3F;
    else if (r_pc == 6'h3F) w_pc_seq = 6'h3E;
    else                    w_pc_seq = {r_pc[4:0], ~(r_pc[5] ^ r_pc[4])};
  end

  // reset gates ready combinationally so a command coinciding with reset is never accepted.
  assign cmd_ready  = r_rdy & ~reset;
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_full     = (r_level == 4'(STACK_DEPTH));
  assign w_pop_lvl  = r_level - 4'd1;
  assign w_push_idx = r_level[IW-1:0];
  assign w_pop_idx  = w_pop_lvl[IW-1:0];
  assign w_pop_dat  = r_stack[w_pop_idx];

  always_comb begin
    w_pc_d   = r_pc;
    w_page_d = r_page;
    w_pb_d   = r_pb;
    w_ch_d   = r_ch;
    w_cb_d   = r_cb;
    w_lvl_d  = r_level;
    w_ovf_d  = r_ovf;
    w_push   = 1'b0;
    if (w_accept) begin
      w_pc_d = w_pc_seq;
      case (cmd_e'(cmd))
        C_BR: begin
          if (status) begin
            w_pc_d = target;
            w_ch_d = r_cb;
            // inside a subroutine the page buffer holds the return page, so the page is kept
            if (r_level == 4'd0) w_page_d = r_pb;
          end
        end
        C_CALL: begin
          if (status) begin
            w_pc_d = target;
            w_ch_d = r_cb;
            w_pb_d = r_page;
            if (!w_full) begin
              w_push   = 1'b1;
              w_page_d = r_pb;
              w_lvl_d  = r_level + 4'd1;
            end else begin
              w_ovf_d = 1'b1;
            end
          end
        end
        C_RETN: begin
          if (r_level != 4'd0) begin
            w_pc_d  = w_pop_dat[5:0];
            w_ch_d  = w_pop_dat[EW-1:10];
            w_lvl_d = w_pop_lvl;
`ifdef TMS_LEGACY_RETN_EN
            w_page_d = r_pb;
`else
            w_page_d = w_pop_dat[9:6];
            w_pb_d   = w_pop_dat[9:6];
`endif
          end else begin
            w_page_d = r_pb;
          end
        end
        C_LDP:  w_pb_d = operand;
        C_COMC: begin
          if (CHAPTER_BITS == 1) w_cb_d = ~r_cb;
          else                   w_cb_d = r_cb + CHAPTER_BITS'(1);
        end
        C_LDC:  w_cb_d = operand[CHAPTER_BITS-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= 6'h00;
      r_page  <= 4'hF;
      r_pb    <= 4'hF;
      r_ch    <= '0;
      r_cb    <= '0;
      r_level <= 4'd0;
      r_ovf   <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      r_pc    <= w_pc_d;
      r_page  <= w_page_d;
      r_pb    <= w_pb_d;
      r_ch    <= w_ch_d;
      r_cb    <= w_cb_d;
      r_level <= w_lvl_d;
      r_ovf   <= w_ovf_d;
      r_rdy   <= 1'b1;
    end
  end

  // stack contents need no reset: the level counter alone defines which entries are live
  always_ff @(posedge clk) begin
    if (w_push) r_stack[w_push_idx] <= {r_ch, r_page, w_pc_seq};
  end

  assign rom_addr       = {r_ch, r_page, r_pc};
  assign stack_level    = r_level;
  assign in_sub         = (r_level != 4'd0);
  assign stack_overflow = r_ovf;

endmodule

// File: tb/tb_tms_sequencer.sv
module tb_tms_sequencer;

  localparam logic [2:0] SEQ = 3'd0, BR = 3'd1, CALL = 3'd2, RETN = 3'd3;
  localparam logic [2:0] LDP = 3'd4, COMC = 3'd5, LDC = 3'd6, SEQ7 = 3'd7;

`ifdef TMS_LEGACY_RETN_EN
  localparam logic [3:0] PX = 4'h5, PY = 4'h9, QF = 4'h1;
`else
  localparam logic [3:0] PX = 4'hF, PY = 4'hF, QF = 4'hF;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [5:0]  target;
  logic [3:0]  operand;
  logic        status;

  logic        rdy1, rdy4, sub1, sub4, ovf1, ovf4;
  logic [10:0] rom1, rom4;
  logic [3:0]  lvl1, lvl4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tms_sequencer #(.CHAPTER_BITS(1), .STACK_DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
    .cmd(cmd), .target(target), .operand(operand), .status(status),
    .rom_addr(rom1), .stack_level(lvl1), .in_sub(sub1), .stack_overflow(ovf1)
  );

  tms_sequencer #(.CHAPTER_BITS(1), .STACK_DEPTH(4)) u_d4 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy4),
    .cmd(cmd), .target(target), .operand(operand), .status(status),
    .rom_addr(rom4), .stack_level(lvl4), .in_sub(sub4), .stack_overflow(ovf4)
  );

  typedef struct packed {
    logic       rst;
    logic       sel4;
    logic       vld;
    logic [2:0] cmd;
    logic [5:0] tgt;
    logic [3:0] opd;
    logic       st;
    logic       ch;
    logic [3:0] pg;
    logic [5:0] pc;
    logic [3:0] lvl;
    logic       ovf;
  } vec_t;

  typedef struct packed {
    logic        sel4;
    logic [10:0] rom;
    logic [3:0]  lvl;
    logic        ovf;
    logic [15:0] idx;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];

  function automatic vec_t mk(input logic rst, input logic sel4, input logic vld, input logic [2:0] c,
                              input logic [5:0] tgt, input logic [3:0] opd, input logic st,
                              input logic ch, input logic [3:0] pg, input logic [5:0] pc,
                              input logic [3:0] lvl, input logic ovf);
    vec_t v;
    v.rst = rst; v.sel4 = sel4; v.vld = vld; v.cmd = c; v.tgt = tgt; v.opd = opd; v.st = st;
    v.ch = ch; v.pg = pg; v.pc = pc; v.lvl = lvl; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    cmd_valid = v.vld;
    cmd       = v.cmd;
    target    = v.tgt;
    operand   = v.opd;
    status    = v.st;
    e.sel4 = v.sel4;
    e.rom  = {v.ch, v.pg, v.pc};
    e.lvl  = v.lvl;
    e.ovf  = v.ovf;
    e.idx  = 16'(idx);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", idx, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("rom_addr",    int'(e.idx), 32'(e.sel4 ? rom4 : rom1), 32'(e.rom));
      chk("stack_level", int'(e.idx), 32'(e.sel4 ? lvl4 : lvl1), 32'(e.lvl));
      chk("in_sub",      int'(e.idx), 32'(e.sel4 ? sub4 : sub1), 32'(e.lvl != 4'd0));
      chk("overflow",    int'(e.idx), 32'(e.sel4 ? ovf4 : ovf1), 32'(e.ovf));
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // reset with a taken BR pending: reset wins, the BR is dropped
    reset = 1'b1; cmd_valid = 1'b1; cmd = BR; target = 6'h2A; operand = 4'h0; status = 1'b1;
    @(posedge clk); #1;
    chk("ready_in_reset",   0, 32'(rdy1), 32'd0);
    chk("ready4_in_reset",  0, 32'(rdy4), 32'd0);
    chk("rst_rom_addr",     0, 32'(rom1), 32'h3C0);
    chk("rst_level",        0, 32'(lvl4), 32'd0);
    chk("rst_overflow",     0, 32'(ovf1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_first_cycle", 0, 32'(rdy1), 32'd0);
    @(posedge clk); #1;
    chk("ready_after",      0, 32'(rdy1), 32'd1);
    chk("br_not_taken_early", 0, 32'(rom1), 32'h3C0);
    cmd_valid = 1'b0;
    @(negedge clk);

    // SEQ walk, idle cycle, LDP + BR taken / not taken
    tbl.push_back(mk(1,0,1,SEQ, 6'h00,4'h0,0, 0,4'hF,6'h01,0,0));
    tbl.push_back(mk(0,0,1,SEQ, 6'h00,4'h0,0, 0,4'hF,6'h03,0,0));
    tbl.push_back(mk(0,0,1,SEQ, 6'h00,4'h0,0, 0,4'hF,6'h07,0,0));
    tbl.push_back(mk(0,0,1,SEQ, 6'h00,4'h0,0, 0,4'hF,6'h0F,0,0));
    tbl.push_back(mk(0,0,1,SEQ, 6'h00,4'h0,0, 0,4'hF,6'h1F,0,0));
    tbl.push_back(mk(0,0,1,SEQ, 6'h00,4'h0,0, 0,4'hF,6'h3F,0,0));
    tbl.push_back(mk(0,0,1,SEQ, 6'h00,4'h0,0, 0,4'hF,6'h3E,0,0));
    tbl.push_back(mk(0,0,1,SEQ, 6'h00,4'h0,0, 0,4'hF,6'h3D,0,0));
    tbl.push_back(mk(0,0,0,BR,  6'h00,4'h0,1, 0,4'hF,6'h3D,0,0));
    tbl.push_back(mk(0,0,1,LDP, 6'h00,4'h2,0, 0,4'hF,6'h3B,0,0));
    tbl.push_back(mk(0,0,1,BR,  6'h10,4'h0,1, 0,4'h2,6'h10,0,0));
    tbl.push_back(mk(0,0,1,BR,  6'h10,4'h0,0, 0,4'h2,6'h20,0,0));
    // depth 1: call, overflow, return; LDP inside subroutine then return
    tbl.push_back(mk(1,0,1,SEQ, 6'h00,4'h0,0, 0,4'hF,6'h01,0,0));
    tbl.push_back(mk(0,0,1,LDP, 6'h00,4'h5,0, 0,4'hF,6'h03,0,0));
    tbl.push_back(mk(0,0,1,CALL,6'h20,4'h0,1, 0,4'h5,6'h20,1,0));
    tbl.push_back(mk(0,0,1,CALL,6'h08,4'h0,1, 0,4'h5,6'h08,1,1));
    tbl.push_back(mk(0,0,1,RETN,6'h00,4'h0,0, 0,PX,  6'h07,0,1));
    tbl.push_back(mk(0,0,1,LDP, 6'h00,4'h3,0, 0,PX,  6'h0F,0,1));
    tbl.push_back(mk(0,0,1,CALL,6'h30,4'h0,1, 0,4'h3,6'h30,1,1));
    tbl.push_back(mk(0,0,1,LDP, 6'h00,4'h9,0, 0,4'h3,6'h21,1,1));
    tbl.push_back(mk(0,0,1,RETN,6'h00,4'h0,0, 0,PY,  6'h1F,0,1));
    tbl.push_back(mk(0,0,1,RETN,6'h00,4'h0,0, 0,PY,  6'h3F,0,1));
    // chapter handling: COMC, BR, CALL/RETN across chapters, LDC, status=0 BR, cmd 7
    tbl.push_back(mk(1,0,1,COMC,6'h00,4'h0,0, 0,4'hF,6'h01,0,0));
    tbl.push_back(mk(0,0,1,BR,  6'h00,4'h0,1, 1,4'hF,6'h00,0,0));
    tbl.push_back(mk(0,0,1,COMC,6'h00,4'h0,0, 1,4'hF,6'h01,0,0));
    tbl.push_back(mk(0,0,1,CALL,6'h10,4'h0,1, 0,4'hF,6'h10,1,0));
    tbl.push_back(mk(0,0,1,RETN,6'h00,4'h0,0, 1,4'hF,6'h03,0,0));
    tbl.push_back(mk(0,0,1,LDC, 6'h00,4'h1,0, 1,4'hF,6'h07,0,0));
    tbl.push_back(mk(0,0,1,BR,  6'h05,4'h0,1, 1,4'hF,6'h05,0,0));
    tbl.push_back(mk(0,0,1,LDC, 6'h00,4'h2,0, 1,4'hF,6'h0B,0,0));
    tbl.push_back(mk(0,0,1,BR,  6'h05,4'h0,0, 1,4'hF,6'h17,0,0));
    tbl.push_back(mk(0,0,1,SEQ7,6'h00,4'h0,0, 1,4'hF,6'h2E,0,0));
    // depth 4: nested calls, BR inside subroutine, LIFO returns, empty RETN, mid-sub reset
    tbl.push_back(mk(1,1,1,LDP, 6'h00,4'h1,0, 0,4'hF,6'h01,0,0));
    tbl.push_back(mk(0,1,1,CALL,6'h08,4'h0,1, 0,4'h1,6'h08,1,0));
    tbl.push_back(mk(0,1,1,CALL,6'h10,4'h0,1, 0,4'hF,6'h10,2,0));
    tbl.push_back(mk(0,1,1,CALL,6'h18,4'h0,1, 0,4'h1,6'h18,3,0));
    tbl.push_back(mk(0,1,1,CALL,6'h20,4'h0,1, 0,4'hF,6'h20,4,0));
    tbl.push_back(mk(0,1,1,BR,  6'h2A,4'h0,1, 0,4'hF,6'h2A,4,0));
    tbl.push_back(mk(0,1,1,RETN,6'h00,4'h0,0, 0,4'h1,6'h30,3,0));
    tbl.push_back(mk(0,1,1,RETN,6'h00,4'h0,0, 0,QF,  6'h20,2,0));
    tbl.push_back(mk(0,1,1,RETN,6'h00,4'h0,0, 0,4'h1,6'h11,1,0));
    tbl.push_back(mk(0,1,1,RETN,6'h00,4'h0,0, 0,QF,  6'h03,0,0));
    tbl.push_back(mk(0,1,1,RETN,6'h00,4'h0,0, 0,QF,  6'h07,0,0));
    tbl.push_back(mk(0,1,1,CALL,6'h3F,4'h0,0, 0,QF,  6'h0F,0,0));
    tbl.push_back(mk(0,1,1,CALL,6'h3F,4'h0,1, 0,QF,  6'h3F,1,0));
    tbl.push_back(mk(1,1,1,SEQ, 6'h00,4'h0,0, 0,4'hF,6'h01,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      apply(tbl[i], i + 1);
    end

    chk("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tms_sequencer.md
TMS_SEQUENCER -- requirements
Module: tms_sequencer

Interface
REQ-001 SHALL have parameter CHAPTER_BITS, default 1, range 1..3, meaning width of chapter and chapter-buffer registers.
REQ-002 SHALL have parameter STACK_DEPTH, default 1, range 1..8, meaning number of subroutine return levels.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  in  1  command present this cycle.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd  in  3  command: 0 SEQ, 1 BR, 2 CALL, 3 RETN, 4 LDP, 5 COMC, 6 LDC, 7 treated as SEQ.
REQ-008 SHALL have port target  in  6  branch/call PC target.
REQ-009 SHALL have port operand  in  4  LDP page value; LDC uses operand[CHAPTER_BITS-1:0].
REQ-010 SHALL have port status  in  1  S flag qualifying BR/CALL.
REQ-011 SHALL have port rom_addr  out  CHAPTER_BITS+10  {chapter, page, pc}.
REQ-012 SHALL have port stack_level  out  4  current number of stacked returns.
REQ-013 SHALL have port in_sub  out  1  stack_level != 0.
REQ-014 SHALL have port stack_overflow  out  1  sticky: a CALL arrived with the stack full.

Function
REQ-015 SHALL compute pc_next from pc as follows: 0x1F->0x3F; 0x3F->0x3E; otherwise {pc[4:0], ~(pc[5]^pc[4])}.
REQ-016 SHALL apply each accepted command in one cycle, with results visible on rom_addr the next cycle.
REQ-017 SHALL load pc <= pc_next for every accepted command except a taken BR, taken CALL, or RETN with the stack non-empty.
REQ-018 SHALL leave all state unchanged in cycles with no accepted command.
REQ-019 LDP SHALL set pb <= operand.
REQ-020 COMC SHALL set cb <= ~cb when CHAPTER_BITS=1, else cb <= cb+1 (wrapping).
REQ-021 LDC SHALL set cb <= operand[CHAPTER_BITS-1:0].
REQ-022 BR with status=1 SHALL set pc <= target and chapter <= cb, and SHALL set page <= pb only when stack_level==0.
REQ-023 BR or CALL with status=0 SHALL act as SEQ.
REQ-024 CALL with status=1 and stack not full SHALL push {chapter, page, pc_next}, then set page <= pb, pb <= page, chapter <= cb, pc <= target, and stack_level+1.
REQ-025 CALL with status=1 and stack full SHALL push nothing, set pb <= page, chapter <= cb, pc <= target, and set stack_overflow.
REQ-026 RETN with stack non-empty SHALL pop and restore pc and chapter from the entry, with stack_level-1.
REQ-027 RETN page restore SHALL follow REQ-036; with an empty stack, RETN SHALL only set page <= pb and pc <= pc_next.
REQ-028 A simultaneous reset and cmd_valid SHALL give reset priority; the command is dropped.

Reset
REQ-029 cmd_ready SHALL be 0 during reset and the first cycle after reset, then 1 permanently.
REQ-030 Reset SHALL set pc=0, page=0xF, pb=0xF, chapter=0, cb=0, stack_level=0, stack_overflow=0.
REQ-031 Reset SHALL leave stack contents don't-care.
REQ-032 Reset asserted mid-subroutine SHALL discard all stacked returns.
REQ-033 Only reset SHALL clear stack_overflow.

Configuration
REQ-034 Macro TMS_LEGACY_RETN_EN SHALL select the RETN page source.
REQ-035 With TMS_LEGACY_RETN_EN defined, a non-empty RETN SHALL set page <= pb and ignore the stacked page; this is TMS1000/TMS1100 behaviour, so LDP inside a subroutine redirects the return page.
REQ-036 Without TMS_LEGACY_RETN_EN, a non-empty RETN SHALL set page <= stacked page and pb <= stacked page.

Verification
REQ-037 Reset, then 8 SEQ -> pc sequence 0x01,0x03,0x07,0x0F,0x1F,0x3F,0x3E,0x3D; page 0xF; chapter 0.
REQ-038 LDP 0x2, then BR target 0x10 status=1 -> rom_addr {0,0x2,0x10}; the same BR with status=0 -> pc = pc_next, page unchanged.
REQ-039 STACK_DEPTH=1: at pc 0x03 page 0xF, LDP 0x5, CALL 0x20 -> page 0x5, pb 0xF, in_sub=1; a second CALL 0x08 -> stack_overflow=1, stack_level stays 1; RETN -> pc 0x07, page 0xF, in_sub=0.
REQ-040 STACK_DEPTH=4: four nested CALLs -> stack_level 4, no overflow; four RETNs -> each pushed pc_next restored in LIFO order; a fifth RETN -> page <= pb, pc advances, stack_level stays 0.
REQ-041 CHAPTER_BITS=1: COMC then BR 0x00 -> chapter 1, rom_addr bit 10 = 1; CALL from chapter 1 after COMC -> RETN restores chapter 1.
REQ-042 Default build, depth 1: CALL, then LDP 0x9 inside the subroutine, then RETN -> page = stacked page, not 0x9; with TMS_LEGACY_RETN_EN defined -> page = 0x9.
